// File: rtl/flags_pkg.sv
// flags_pkg: shared flag indices, default sizes and the flag vector type.
// Used by flag_stack_reg (flag register) and flag_lifo (save/restore stack).
package flags_pkg;
    localparam int FLAG_OV = 0;
    localparam int FLAG_CY = 1;
    localparam int FLAG_NG = 2;
    localparam int FLAG_ZR = 3;
    localparam int NFLAGS_DEF = 4;
    localparam int DEPTH_DEF = 4;
    typedef logic [NFLAGS_DEF-1:0] flag_vec_t;
endpackage

// File: rtl/flag_lifo.sv
// flag_lifo: DEPTH x NFLAGS save/restore stack with saturating pointer.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   push_i, pop_i     save wr_data_i / drop top entry (both at once: neither)
//   wr_data_i         value saved on push
//   rd_data_o         current top entry (valid when not empty)
//   cnt_o             occupied entries
//   full_o, empty_o   decoded from the registered count
//   err_o             this cycle's request is illegal (combinational pulse)
module flag_lifo #(
    parameter int NFLAGS = 4,
    parameter int DEPTH = 4,
    localparam int W = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [NFLAGS-1:0] wr_data_i,
    output logic [NFLAGS-1:0] rd_data_o,
    output logic [W-1:0]      cnt_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              err_o
);
    logic [NFLAGS-1:0] mem_q [DEPTH];
    logic [W-1:0] ptr_q, ptr_d;
    logic do_push, do_pop;

    assign full_o  = ptr_q == W'(DEPTH);
    assign empty_o = ptr_q == '0;
    assign cnt_o   = ptr_q;
    assign do_push = push_i & ~pop_i & ~full_o;
    assign do_pop  = pop_i & ~push_i & ~empty_o;
    assign err_o   = (push_i & pop_i) | (pop_i & empty_o) | (push_i & full_o);
    assign ptr_d   = do_push ? ptr_q + W'(1) : do_pop ? ptr_q - W'(1) : ptr_q;

    // Entry-by-entry decode keeps every index inside the array bounds.
    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < DEPTH; i++)
            if (ptr_q == W'(i + 1)) rd_data_o = mem_q[i];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            ptr_q <= ptr_d;
            for (int i = 0; i < DEPTH; i++)
                if (do_push && ptr_q == W'(i)) mem_q[i] <= wr_data_i;
        end
    end
endmodule

// File: rtl/flag_stack_reg.sv
// flag_stack_reg: masked, partly sticky status-flag register with save/restore stack.
// Ports:
//   CLK, RESET        clock, asynchronous active-high reset
//   w, wmask, in      masked flag write from the ALU
//   clr               clears sticky flags and stk_err
//   push, pop         save / restore the flag context
//   flags + aliases   registered flag vector (OVERFLOW=0, CARRY=1, NEGATIVE=2, ZERO=3)
//   depth_cnt, stk_full, stk_empty, stk_err   stack status
module flag_stack_reg
    import flags_pkg::*;
#(
    parameter int NFLAGS = NFLAGS_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter logic [NFLAGS-1:0] STICKY_MASK = '0,
    parameter logic [NFLAGS-1:0] RESET_VAL = '0,
    localparam int W = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              w,
    input  logic [NFLAGS-1:0] wmask,
    input  logic [NFLAGS-1:0] in,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    output logic [NFLAGS-1:0] flags,
    output logic              OVERFLOW,
    output logic              CARRY,
    output logic              NEGATIVE,
    output logic              ZERO,
    output logic [W-1:0]      depth_cnt,
    output logic              stk_full,
    output logic              stk_empty,
    output logic              stk_err
);
    logic [NFLAGS-1:0] flags_q, flags_d, after_clr, wr_val, after_w, top;
    logic err_q, err_d, lifo_err;

    flag_lifo #(.NFLAGS(NFLAGS), .DEPTH(DEPTH)) u_lifo (
        .clk_i(CLK), .rst_i(RESET), .push_i(push), .pop_i(pop),
        .wr_data_i(flags_q), .rd_data_o(top), .cnt_o(depth_cnt),
        .full_o(stk_full), .empty_o(stk_empty), .err_o(lifo_err)
    );

    // clr first, then w: sticky bits OR in the new value, so clr+w can re-set them.
    assign after_clr = clr ? flags_q & ~STICKY_MASK : flags_q;
    assign wr_val    = in | (after_clr & STICKY_MASK);
    assign after_w   = w ? (after_clr & ~wmask) | (wr_val & wmask) : after_clr;
    // A lone pop owns the flags: restore, or hold them if the stack is empty.
    assign flags_d   = (pop & ~push) ? (stk_empty ? flags_q : top) : after_w;
    assign err_d     = lifo_err ? 1'b1 : clr ? 1'b0 : err_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            flags_q <= RESET_VAL;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            err_q   <= err_d;
        end
    end

    assign flags    = flags_q;
    assign stk_err  = err_q;
    assign OVERFLOW = flags_q[FLAG_OV];
    assign CARRY    = flags_q[FLAG_CY];
    assign NEGATIVE = flags_q[FLAG_NG];
    assign ZERO     = flags_q[FLAG_ZR];
endmodule

// File: tb/tb_flag_stack_reg.sv
// tb_flag_stack_reg: directed bench with a queue-based reference model.
module tb_flag_stack_reg;
    localparam int NF = 4;
    localparam int DP = 4;
    localparam logic [NF-1:0] STICKY = 4'b0001;

    logic CLK = 0, RESET = 1;
    logic w = 0, clr = 0, push = 0, pop = 0;
    logic [NF-1:0] wmask = 0, in_v = 0;
    logic [NF-1:0] flags;
    logic OVERFLOW, CARRY, NEGATIVE, ZERO, stk_full, stk_empty, stk_err;
    logic [2:0] depth_cnt;

    int checks = 0, errors = 0;

    flag_stack_reg #(.NFLAGS(NF), .DEPTH(DP), .STICKY_MASK(STICKY), .RESET_VAL(4'b0000)) dut (
        .CLK(CLK), .RESET(RESET), .w(w), .wmask(wmask), .in(in_v), .clr(clr),
        .push(push), .pop(pop), .flags(flags), .OVERFLOW(OVERFLOW), .CARRY(CARRY),
        .NEGATIVE(NEGATIVE), .ZERO(ZERO), .depth_cnt(depth_cnt), .stk_full(stk_full),
        .stk_empty(stk_empty), .stk_err(stk_err)
    );

    always #5 CLK = ~CLK;

    // Reference model: flags as a vector, the stack as a queue.
    logic [NF-1:0] m_flags;
    logic m_err;
    logic [NF-1:0] stk[$];

    always @(posedge CLK or posedge RESET) begin
        logic [NF-1:0] nf;
        logic ne;
        if (RESET) begin
            m_flags = '0;
            m_err = 0;
            stk.delete();
        end else begin
            nf = m_flags;
            ne = m_err;
            if (clr) begin
                nf = nf & ~STICKY;
                ne = 0;
            end
            if (w)
                for (int i = 0; i < NF; i++)
                    if (wmask[i]) nf[i] = STICKY[i] ? (nf[i] | in_v[i]) : in_v[i];
            if (push && pop) ne = 1;
            else if (pop) begin
                if (stk.size() == 0) begin
                    ne = 1;
                    nf = m_flags;
                end else nf = stk.pop_back();
            end else if (push) begin
                if (stk.size() == DP) ne = 1;
                else stk.push_back(m_flags);
            end
            m_flags = nf;
            m_err = ne;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (!RESET) begin
            chk("cmp_flags", int'(flags), int'(m_flags));
            chk("cmp_aliases", int'({ZERO, NEGATIVE, CARRY, OVERFLOW}), int'(m_flags));
            chk("cmp_depth", int'(depth_cnt), stk.size());
            chk("cmp_full", int'(stk_full), int'(stk.size() == DP));
            chk("cmp_empty", int'(stk_empty), int'(stk.size() == 0));
            chk("cmp_err", int'(stk_err), int'(m_err));
        end
    end

    // Applies one cycle of inputs, then idles them shortly after the edge.
    task automatic step(input logic iw, input logic [NF-1:0] iwm, input logic [NF-1:0] iin,
                        input logic iclr, input logic ipush, input logic ipop);
        w = iw; wmask = iwm; in_v = iin; clr = iclr; push = ipush; pop = ipop;
        @(posedge CLK);
        #2;
        w = 0; wmask = 0; in_v = 0; clr = 0; push = 0; pop = 0;
    endtask

    initial begin
        #12 RESET = 0;
        chk("rst_flags", int'(flags), 0);
        chk("rst_empty", int'(stk_empty), 1);
        chk("rst_err", int'(stk_err), 0);
        // Asynchronous reset mid-cycle with flags=1010, depth 2
        step(1, 4'b1111, 4'b1010, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("pre_rst_flags", int'(flags), 4'b1010);
        chk("pre_rst_depth", int'(depth_cnt), 2);
        #1 RESET = 1;
        #1;
        chk("arst_flags", int'(flags), 0);
        chk("arst_depth", int'(depth_cnt), 0);
        chk("arst_empty", int'(stk_empty), 1);
        #3 RESET = 0;
        @(posedge CLK);
        #2;
        // Masked write
        step(1, 4'b0101, 4'b1111, 0, 0, 0);
        chk("mask_flags", int'(flags), 4'b0101);
        chk("mask_alias", int'({ZERO, NEGATIVE, CARRY, OVERFLOW}), 4'b0101);
        // Sticky bit 0
        step(1, 4'b1111, 4'b0000, 0, 0, 0);
        chk("sticky_hold", int'(flags), 4'b0001);
        step(0, 0, 0, 1, 0, 0);
        chk("sticky_clr", int'(flags), 4'b0000);
        step(1, 4'b0001, 4'b0001, 1, 0, 0);
        chk("sticky_clr_w", int'(flags), 4'b0001);
        step(1, 4'b0000, 4'b1111, 0, 0, 0);
        chk("wmask_zero", int'(flags), 4'b0001);
        // Push saves pre-write value
        step(1, 4'b1111, 4'b0011, 0, 0, 0);
        step(1, 4'b1111, 4'b1100, 1, 1, 0);
        chk("push_w_flags", int'(flags), 4'b1100);
        chk("push_w_depth", int'(depth_cnt), 1);
        step(0, 0, 0, 0, 0, 1);
        chk("pop_flags", int'(flags), 4'b0011);
        chk("pop_depth", int'(depth_cnt), 0);
        // Fill, overflow, LIFO drain, underflow
        step(1, 4'b1111, 4'b0100, 1, 1, 0);
        step(1, 4'b1111, 4'b0110, 1, 1, 0);
        step(1, 4'b1111, 4'b1000, 1, 1, 0);
        step(1, 4'b1111, 4'b1010, 1, 1, 0);
        chk("full_noerr", int'(stk_err), 0);
        step(1, 4'b1111, 4'b1110, 1, 1, 0);
        chk("ovf_depth", int'(depth_cnt), 4);
        chk("ovf_full", int'(stk_full), 1);
        chk("ovf_err", int'(stk_err), 1);
        chk("ovf_flags", int'(flags), 4'b1110);
        step(0, 0, 0, 0, 0, 1);
        chk("lifo_pop1", int'(flags), 4'b1000);
        step(0, 0, 0, 0, 0, 1);
        chk("lifo_pop2", int'(flags), 4'b0110);
        step(0, 0, 0, 0, 0, 1);
        chk("lifo_pop3", int'(flags), 4'b0100);
        step(0, 0, 0, 0, 0, 1);
        chk("lifo_pop4", int'(flags), 4'b0011);
        step(1, 4'b1111, 4'b1111, 0, 0, 1);
        chk("udf_flags", int'(flags), 4'b0011);
        chk("udf_err", int'(stk_err), 1);
        step(0, 0, 0, 1, 0, 0);
        chk("clr_err", int'(stk_err), 0);
        chk("clr_flags", int'(flags), 4'b0010);
        // Push and pop together
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1);
        chk("pp_depth", int'(depth_cnt), 1);
        chk("pp_flags", int'(flags), 4'b0010);
        chk("pp_err", int'(stk_err), 1);
        step(1, 4'b1111, 4'b0100, 1, 1, 1);
        chk("pp_w_flags", int'(flags), 4'b0100);
        chk("pp_clr_err", int'(stk_err), 1);
        step(0, 0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
